// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO register and divide unit.
//   op_e      : 3-bit operation code presented by the pipeline
//   state_e   : control FSM states (IDLE, RUN, FIX)
//   DIV_ITERS : restoring divide steps per division
//   DIV0_QUOT : quotient written to LO on a divide by zero
package mips_hilo_pkg;

    typedef enum logic [2:0] {
        NOP    = 3'd0,
        LDPROD = 3'd1,
        MADD   = 3'd2,
        MSUB   = 3'd3,
        MTHI   = 3'd4,
        MTLO   = 3'd5,
        DIV    = 3'd6,
        DIVU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam int          DIV_ITERS = 32;
    localparam int          DIV_CNT_W = $clog2(DIV_ITERS);
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_div_unit_if.sv
// Request/result bundle between the pipeline and the HI/LO unit.
//   master : pipeline side, drives the request, reads status and HI/LO
//   slave  : unit side, consumes the request, drives status and HI/LO
interface hilo_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] alu_lo;
    logic [WIDTH-1:0] alu_hi;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             op_ready;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op, alu_lo, alu_hi, rs_val, rt_val,
        input  op_ready, busy, done, div0, hi, lo
    );

    modport slave (
        input  op_valid, op, alu_lo, alu_hi, rs_val, rt_val,
        output op_ready, busy, done, div0, hi, lo
    );
endinterface

// File: rtl/hilo_div_unit_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per i_step cycle.
//   i_start    : load dividend/divisor magnitudes, clear remainder and counter
//   i_step     : perform one shift / trial-subtract step
//   o_quot     : quotient (valid after DIV_ITERS steps)
//   o_rem      : remainder (valid after DIV_ITERS steps)
//   o_last     : the step performed this cycle is the final one
module div_core
    import mips_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_last
);
    // r_quot starts as the dividend; its MSB feeds the remainder each step
    // while the new quotient bit shifts in at the bottom.
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_divisor;
    logic [DIV_CNT_W-1:0] r_cnt;

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_divisor};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
        end else if (i_start) begin
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
            r_cnt     <= '0;
        end else if (i_step) begin
            // Bit WIDTH of the trial is the borrow: clear means non-negative.
            if (!w_trial[WIDTH]) begin
                r_rem  <= w_trial[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_last = (r_cnt == DIV_CNT_W'(DIV_ITERS - 1));
endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register unit: product load, MADD/MSUB accumulate, MTHI/MTLO moves
// and a multi-cycle signed/unsigned restoring divide.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of hilo_div_unit_if (request in, status and HI/LO out)
module hilo_div_unit
    import mips_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hilo_div_unit_if.slave bus
);
    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_done, r_div0;
    logic             r_neg_q, r_neg_r, r_rt_zero;
    logic [WIDTH-1:0] r_rs_raw;

    op_e                w_op;
    logic               w_accept, w_is_div, w_start, w_step, w_last;
    logic               w_sa, w_sb;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quot, w_rem;
    logic [2*WIDTH-1:0] w_acc, w_prod;

    assign w_op     = op_e'(bus.op);
    assign w_accept = bus.op_valid && (r_state == IDLE);
    assign w_is_div = (w_op == DIV) || (w_op == DIVU);

    // Signs only matter for DIV; DIVU treats both operands as raw magnitudes.
    assign w_sa    = (w_op == DIV) && bus.rs_val[WIDTH-1];
    assign w_sb    = (w_op == DIV) && bus.rt_val[WIDTH-1];
    assign w_mag_a = w_sa ? -bus.rs_val : bus.rs_val;
    assign w_mag_b = w_sb ? -bus.rt_val : bus.rt_val;

    assign w_acc  = {r_hi, r_lo};
    assign w_prod = {bus.alu_hi, bus.alu_lo};

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: if (w_accept && w_is_div) begin
                w_start      = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) w_state_next = FIX;
            end
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_div0    <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rt_zero <= 1'b0;
            r_rs_raw  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && (w_op != NOP)) begin
                r_div0 <= 1'b0;
                case (w_op)
                    LDPROD: begin
                        {r_hi, r_lo} <= w_prod;
                        r_done       <= 1'b1;
                    end
                    MADD: begin
                        {r_hi, r_lo} <= w_acc + w_prod;
                        r_done       <= 1'b1;
                    end
                    MSUB: begin
                        {r_hi, r_lo} <= w_acc - w_prod;
                        r_done       <= 1'b1;
                    end
                    MTHI: begin
                        r_hi   <= bus.rs_val;
                        r_done <= 1'b1;
                    end
                    MTLO: begin
                        r_lo   <= bus.rs_val;
                        r_done <= 1'b1;
                    end
                    default: begin
                        r_neg_q   <= w_sa ^ w_sb;
                        r_neg_r   <= w_sa;
                        r_rt_zero <= (bus.rt_val == '0);
                        r_rs_raw  <= bus.rs_val;
                    end
                endcase
            end else if (r_state == FIX) begin
                if (r_rt_zero) begin
                    r_lo   <= DIV0_QUOT[WIDTH-1:0];
                    r_hi   <= r_rs_raw;
                    r_div0 <= 1'b1;
                end else begin
                    r_lo <= r_neg_q ? -w_quot : w_quot;
                    r_hi <= r_neg_r ? -w_rem  : w_rem;
                end
                r_done <= 1'b1;
            end
        end
    end

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_step     (w_step),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_last     (w_last)
    );

    assign bus.busy     = (r_state != IDLE);
    assign bus.op_ready = (r_state == IDLE);
    assign bus.done     = r_done;
    assign bus.div0     = r_div0;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_hilo_div_unit.sv
module tb_hilo_div_unit;
    import mips_hilo_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    // Reference state
    logic [31:0] m_hi, m_lo;
    logic        m_div0;

    hilo_div_unit_if #(.WIDTH(32)) bus ();

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural model: 64-bit arithmetic and native 64-bit signed division.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [31:0] ah,
                               input logic [31:0] al);
        logic [63:0] acc, prod;
        longint      la, lb, q, r;
        acc  = {m_hi, m_lo};
        prod = {ah, al};
        if (op != 3'd0) m_div0 = 1'b0;
        case (op)
            3'd1: {m_hi, m_lo} = prod;
            3'd2: {m_hi, m_lo} = acc + prod;
            3'd3: {m_hi, m_lo} = acc - prod;
            3'd4: m_hi = rs;
            3'd5: m_lo = rs;
            3'd6, 3'd7: begin
                if (rt == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = rs;
                    m_div0 = 1'b1;
                end else begin
                    if (op == 3'd6) begin
                        la = {{32{rs[31]}}, rs};
                        lb = {{32{rt[31]}}, rt};
                    end else begin
                        la = {32'd0, rs};
                        lb = {32'd0, rt};
                    end
                    q = la / lb;
                    r = la % lb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            default: ;
        endcase
    endtask

    // Present an op, wait for acceptance, check completion against the model.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] ah, input logic [31:0] al);
        int n;
        bus.op       = op;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.alu_hi   = ah;
        bus.alu_lo   = al;
        bus.op_valid = 1'b1;
        n = 0;
        while (!bus.op_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready"}, 32'(bus.op_ready), 32'd1);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        model_apply(op, rs, rt, ah, al);
        if (op >= 3'd6) begin
            n = 0;
            while (bus.busy && n < 100) begin
                @(posedge clk); #1; n++;
            end
            check({tag, "_busy_cycles"}, 32'(n + 1), 32'd34);
        end
        check({tag, "_done"}, 32'(bus.done), (op != 3'd0) ? 32'd1 : 32'd0);
        check({tag, "_hi"}, bus.hi, m_hi);
        check({tag, "_lo"}, bus.lo, m_lo);
        check({tag, "_div0"}, 32'(bus.div0), 32'(m_div0));
        $display("op=%0d rs=%h rt=%h prod=%h_%h -> hi=%h lo=%h div0=%0b",
                 op, rs, rt, ah, al, bus.hi, bus.lo, bus.div0);
        @(posedge clk); #1;
        check({tag, "_done_pulse_end"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [31:0] pre_hi, pre_lo;
        logic [2:0]  rop;
        logic [31:0] rrs, rrt;
        int          n;
        bit          held_ok;

        n_checks = 0;
        n_fails  = 0;
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.alu_hi   = '0;
        bus.alu_lo   = '0;
        m_hi = '0; m_lo = '0; m_div0 = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_div0", 32'(bus.div0), 32'd0);
        check("rst_ready", 32'(bus.op_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed division cases
        run_op("div_7_2",      3'd6, 32'd7,          32'd2,          0, 0);
        run_op("div_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,          0, 0);
        run_op("div_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  0, 0);
        run_op("divu_max_2",   3'd7, 32'hFFFF_FFFF,  32'd2,          0, 0);
        run_op("div_5_0",      3'd6, 32'd5,          32'd0,          0, 0);
        run_op("mtlo_clr",     3'd5, 32'hCAFE_0001,  32'd0,          0, 0);

        // Accumulate sequence with carry across the word boundary
        run_op("ldprod",       3'd1, 0, 0, 32'd0, 32'hFFFF_FFFF);
        run_op("madd",         3'd2, 0, 0, 32'd0, 32'd1);
        run_op("msub",         3'd3, 0, 0, 32'd0, 32'd2);
        run_op("nop",          3'd0, 32'h1111, 32'h2222, 32'h3, 32'h4);

        // Busy hold: MTHI held valid during a division waits for op_ready.
        run_op("ld_pre",       3'd1, 0, 0, 32'hAAAA_0000, 32'h0000_5555);
        pre_hi = bus.hi;
        pre_lo = bus.lo;
        bus.op = 3'd6; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.op_valid = 1'b1;
        @(posedge clk); #1;
        model_apply(3'd6, 32'd100, 32'd7, 0, 0);
        bus.op = 3'd4; bus.rs_val = 32'h1234;
        held_ok = 1'b1;
        n = 0;
        while (bus.busy && n < 100) begin
            if (bus.hi !== pre_hi || bus.lo !== pre_lo) held_ok = 1'b0;
            @(posedge clk); #1; n++;
        end
        check("hold_hilo_stable", 32'(held_ok), 32'd1);
        check("hold_div_cycles", 32'(n + 1), 32'd34);
        check("hold_div_done", 32'(bus.done), 32'd1);
        check("hold_div_lo", bus.lo, m_lo);
        check("hold_div_hi", bus.hi, m_hi);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        model_apply(3'd4, 32'h1234, 0, 0, 0);
        check("hold_mthi_done", 32'(bus.done), 32'd1);
        check("hold_mthi_hi", bus.hi, 32'h1234);
        check("hold_mthi_lo", bus.lo, m_lo);
        $display("busy-hold: hi=%h lo=%h", bus.hi, bus.lo);

        // Asynchronous reset mid-division
        bus.op = 3'd7; bus.rs_val = 32'hDEAD_BEEF; bus.rt_val = 32'd3; bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_ready", 32'(bus.op_ready), 32'd1);
        $display("async reset during RUN: hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);
        #1;
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0; m_div0 = 1'b0;
        @(posedge clk); #1;

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            rrs = $urandom;
            case ($urandom_range(0, 3))
                0:       rrt = 32'd0;
                1:       rrt = 32'($urandom_range(1, 20));
                2:       rrt = -32'($urandom_range(1, 20));
                default: rrt = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), rop, rrs, rrt, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/hilo_div_unit.md
# hilo_div_unit

HI/LO register unit that sits directly downstream of the ALU in the mini-MIPS datapath. It captures the 64-bit `MUL`/`MULU` product the ALU drives on `out`/`out_high`, and performs `MADD`/`MSUB` accumulation and `MTHI`/`MTLO` moves. It also runs signed and unsigned division as a 32-iteration restoring divider. The pipeline stalls on `busy` while a division is in progress.

## Interface
- `WIDTH`, 32: datapath width; HI and LO are each `WIDTH` bits.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `op_valid` in 1: a request is presented on `op`.
- `op` in 3: 0 `NOP`, 1 `LDPROD`, 2 `MADD`, 3 `MSUB`, 4 `MTHI`, 5 `MTLO`, 6 `DIV`, 7 `DIVU`.
- `alu_lo` in WIDTH: ALU `out`, low product word.
- `alu_hi` in WIDTH: ALU `out_high`, high product word.
- `rs_val` in WIDTH: dividend, or the move source.
- `rt_val` in WIDTH: divisor.
- `op_ready` out 1: the unit can accept an op this cycle; equals `!busy`.
- `busy` out 1: a division is in flight.
- `done` out 1: one-cycle pulse after any accepted non-`NOP` op completes.
- `div0` out 1: the last accepted division had `rt_val == 0`; held until the next accepted op.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- **Accept:** an op is accepted on a clock edge where `op_valid && op_ready`.
  - Ops presented while `busy` are not accepted. Upstream holds the op until accepted.
  - `NOP` is accepted but changes nothing and produces no `done`.
- **Single-cycle ops:** these write HI/LO at the accept edge.
  - `LDPROD`: `{hi,lo} <= {alu_hi,alu_lo}`.
  - `MADD`: `{hi,lo} <= {hi,lo} + {alu_hi,alu_lo}`. This is a 64-bit two's-complement add; carries out of bit 63 are discarded.
  - `MSUB`: `{hi,lo} <= {hi,lo} - {alu_hi,alu_lo}`, with the same 64-bit wrap.
  - `MTHI`: `hi <= rs_val`. LO is untouched.
  - `MTLO`: `lo <= rs_val`. HI is untouched.
- **FSM:** states `IDLE`, `RUN`, `FIX`.
- **IDLE, on accepting `DIV`/`DIVU`:**
  - Latch the magnitudes |rs|, |rt|. For `DIVU` the values are taken raw.
  - Latch the sign of the quotient (sa^sb) and the sign of the remainder (sa).
  - Clear the remainder register and the iteration counter, then go to `RUN`.
- **RUN:** performs one restoring step per cycle.
  - Shift the remainder left and bring in the next dividend bit, MSB first.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1.
  - After the step with counter value 31, go to `FIX`.
- **FIX:** apply signs, write HI/LO, return to `IDLE`.
  - `lo <= quotient`, negated if sa^sb.
  - `hi <= remainder`, negated if sa. Division truncates toward zero.
- **Divide by zero:** the FSM still runs the full sequence.
  - FIX forces `lo <= 32'hFFFFFFFF` and `hi <= rs_val` (the latched raw value).
  - `div0` is set at FIX.
- **Signed overflow (`0x80000000 / -1`):** `lo = 0x80000000`, `hi = 0`. This falls out of the magnitude algorithm; no special case is needed.
- **`div0` clearing:** cleared at the next accept edge of any non-`NOP` op.

## Timing
- **Reset values:** `hi`, `lo` = 0; `busy`, `done`, `div0` = 0; `op_ready` = 1; FSM in `IDLE`.
- **Single-cycle op** accepted at edge k:
  - `hi`/`lo` are valid after edge k.
  - `done` is high for the cycle following edge k.
- **Division** accepted at edge k:
  - `busy` is high from edge k to edge k+33. RUN steps occupy edges k+1..k+32, and FIX completes at edge k+33.
  - `hi`/`lo`/`div0` are valid after edge k+33.
  - `done` is high for the cycle following edge k+33, and `op_ready` returns in that same cycle.
- **Back-to-back:** a new op may be accepted in the cycle in which `done` is high.
- **Reset during RUN/FIX:** `rst_n` low immediately forces all reset values, including `hi`/`lo` = 0. The partial result is discarded.
- **Busy hold:** HI/LO do not change during `RUN`. Reads of `hi`/`lo` while `busy` return the pre-division values.

## Structure
- **Shared package `mips_hilo_pkg`:**
  - Op enum (`NOP`..`DIVU`, 3 bits).
  - FSM state enum.
  - `DIV_ITERS` = 32.
  - `DIV0_QUOT` = 32'hFFFFFFFF.
- **Sub-module `div_core`:**
  - Holds the remainder/quotient/divisor registers and the counter, plus the per-cycle restoring step.
  - Controlled by start/step signals from the top-level FSM.
  - Sign handling and HI/LO writeback stay in `hilo_div_unit`.

## Test plan
- **DIV 7 / 2:** `op_ready` low for 34 cycles → `lo`=3, `hi`=1, single `done` pulse at k+34, `div0`=0.
- **DIV signed:** -7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **DIVU 0xFFFFFFFF / 2:** → `lo`=0x7FFFFFFF, `hi`=1.
- **DIV 5 / 0:** → `lo`=0xFFFFFFFF, `hi`=5, `div0`=1. A following `MTLO` clears `div0`.
- **MADD:** `LDPROD` {0, 0xFFFFFFFF}, then `MADD` with product {0, 1} → `hi`=1, `lo`=0. Then `MSUB` {0, 2} → `hi`=0, `lo`=0xFFFFFFFE.
- **Busy and reset:** hold `MTHI` 0x1234 with `op_valid` during a division → not accepted until `op_ready` returns. Assert `rst_n`=0 at RUN cycle 10 → `hi`=`lo`=0, `busy`=0, `op_ready`=1 with no clock edge required.
